// File: rtl/sd_pkg.sv
// Shared SD definitions: FSM state encodings, block geometry and address forming.
// Used by both the recorder and the playback driver.
// Pure declarations, no logic.
package sd_pkg;

    localparam int SD_BLOCK_BYTES = 512;
    localparam int BLOCK_IDX_W    = 23;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_ARM      = 3'b001,
        ST_PREFETCH = 3'b010,
        ST_WRITE    = 3'b011,
        ST_CLOSE    = 3'b100
    } sd_state_e;

    // Byte address of an SD block: block index times 512.
    function automatic logic [31:0] sd_block_addr(input logic [BLOCK_IDX_W-1:0] blk);
        return {blk, 9'b0};
    endfunction

endpackage

// File: rtl/sd_byte_serializer.sv
// Holds the current 16-bit sample and presents it as two bytes, low byte first.
// Latency: fifo_rd pulse the cycle after fetch_i, hold loaded two cycles after fetch_i; pad words load at once.
// Backpressure: none; relies on successive controller wreqs being at least 3 cycles apart.
module sd_byte_serializer
    import sd_pkg::*;
#(
    parameter logic [15:0] PAD_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm_i,         // recording accepted: clear the sticky underrun flag
    input  logic        clear_i,       // block start: next byte is the low byte
    input  logic        fetch_i,       // fetch the next word (FIFO or pad)
    input  logic        stop_req_i,
    input  logic        wreq_i,        // controller consumed the current byte
    input  logic        fifo_empty_i,
    output logic        fifo_rd_o,
    input  logic [15:0] fifo_data_i,
    output logic [7:0]  wdata_o,
    output logic        byte_sel_o,
    output logic        word_real_o
);

    logic [15:0] hold_q, hold_d;
    logic        real_q, real_d;
    logic        sel_q, sel_d;
    logic        rd_q, rd_d;
    logic        ld_q, ld_d;
    logic        underrun_q, underrun_d;
    logic [7:0]  wdata_q, wdata_d;

    // Next-state: FIFO read pipeline, pad substitution, byte toggle and output byte mux.
    always_comb begin
        hold_d     = hold_q;
        real_d     = real_q;
        sel_d      = sel_q;
        rd_d       = 1'b0;
        ld_d       = rd_q;
        underrun_d = arm_i ? 1'b0 : underrun_q;

        // FIFO data is valid the cycle after the read strobe.
        if (ld_q) begin
            hold_d = fifo_data_i;
            real_d = 1'b1;
        end

        if (clear_i) begin
            sel_d = 1'b0;
        end else if (wreq_i) begin
            sel_d = ~sel_q;
        end

        if (fetch_i) begin
            if (!fifo_empty_i) begin
                rd_d = 1'b1;
            end else begin
                // Nothing to read: pad. Without a pending stop this is an underrun.
                hold_d = PAD_WORD;
                real_d = 1'b0;
                if (!stop_req_i) begin
                    underrun_d = 1'b1;
                end
            end
        end

        // Output byte follows the next hold/byte_sel so it is always coherent with them.
        wdata_d = sel_d ? hold_d[15:8] : hold_d[7:0];
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            real_q     <= 1'b0;
            sel_q      <= 1'b0;
            rd_q       <= 1'b0;
            ld_q       <= 1'b0;
            underrun_q <= 1'b0;
            wdata_q    <= '0;
        end else begin
            hold_q     <= hold_d;
            real_q     <= real_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            ld_q       <= ld_d;
            underrun_q <= underrun_d;
            wdata_q    <= wdata_d;
        end
    end

    assign fifo_rd_o   = rd_q;
    assign wdata_o     = wdata_q;
    assign byte_sel_o  = sel_q;
    assign word_real_o = real_q;

endmodule

// File: rtl/sd_recorder.sv
// Records 16-bit FIFO samples to consecutive 512-byte SD blocks; stop flushes a zero-padded final block.
// Latency: start with fifo_prog high -> SDctrl_start 3 cycles later; one byte per SDctrl_wreq.
// Backpressure: waits for fifo_prog (or stop) before each block and for controller idle before advancing.
module sd_recorder
    import sd_pkg::*;
#(
    parameter int          SAMPLES_PER_BLOCK = SD_BLOCK_BYTES / 2,
    parameter logic [15:0] PAD_WORD          = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [BLOCK_IDX_W-1:0] start_block,
    input  logic                   fifo_empty,
    input  logic                   fifo_prog,
    output logic                   fifo_rd,
    input  logic [15:0]            fifo_data,
    input  logic                   SDctrl_available,
    input  logic                   SDctrl_wreq,
    output logic                   SDctrl_start,
    output logic [31:0]            SDctrl_address,
    output logic [7:0]             SDctrl_wdata,
    output logic                   busy,
    output logic [31:0]            nb_data,
    output logic [2:0]             state
);

    localparam int CNT_W = $clog2(SAMPLES_PER_BLOCK + 1);

    sd_state_e              state_q;
    logic                   pf_phase_q;
    logic [BLOCK_IDX_W-1:0] block_q;
    logic [31:0]            nb_data_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stop_req_q;
    logic                   sd_start_q;

    logic             byte_sel;
    logic             word_real;
    logic             wreq_w;
    logic             hi_wreq;
    logic             block_done;
    logic             arm_go;
    logic             fetch;
    logic             start_acc;
    logic             load_blk;
    logic [CNT_W-1:0] cnt_inc;

    // Decision terms shared by the FSM and the serializer.
    always_comb begin
        wreq_w     = SDctrl_wreq && (state_q == ST_WRITE);
        hi_wreq    = wreq_w && byte_sel;
        cnt_inc    = cnt_q + CNT_W'(1);
        block_done = hi_wreq && (cnt_inc == CNT_W'(SAMPLES_PER_BLOCK));
        arm_go     = (state_q == ST_ARM) && (fifo_prog || (stop_req_q && !fifo_empty));
        fetch      = arm_go || (hi_wreq && !block_done);
        start_acc  = (state_q == ST_IDLE) && start;
        load_blk   = (state_q == ST_PREFETCH) && pf_phase_q;
    end

    sd_byte_serializer #(
        .PAD_WORD (PAD_WORD)
    ) u_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm_i        (start_acc),
        .clear_i      (load_blk),
        .fetch_i      (fetch),
        .stop_req_i   (stop_req_q),
        .wreq_i       (wreq_w),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_o    (fifo_rd),
        .fifo_data_i  (fifo_data),
        .wdata_o      (SDctrl_wdata),
        .byte_sel_o   (byte_sel),
        .word_real_o  (word_real)
    );

    // Recording FSM with block/sample counters and the command handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pf_phase_q <= 1'b0;
            block_q    <= '0;
            nb_data_q  <= '0;
            cnt_q      <= '0;
            stop_req_q <= 1'b0;
            sd_start_q <= 1'b0;
        end else begin
            if ((state_q != ST_IDLE) && stop) begin
                stop_req_q <= 1'b1;
            end
            // Command request drops once the controller has gone busy.
            if (sd_start_q && !SDctrl_available) begin
                sd_start_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        block_q    <= start_block;
                        nb_data_q  <= '0;
                        stop_req_q <= 1'b0;
                        state_q    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (arm_go) begin
                        pf_phase_q <= 1'b0;
                        state_q    <= ST_PREFETCH;
                    end else if (stop_req_q && fifo_empty) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PREFETCH: begin
                    // Phase 0: FIFO read in flight; phase 1: word lands in hold.
                    if (!pf_phase_q) begin
                        pf_phase_q <= 1'b1;
                    end else begin
                        pf_phase_q <= 1'b0;
                        sd_start_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (hi_wreq) begin
                        cnt_q <= cnt_inc;
                        if (word_real) begin
                            nb_data_q <= nb_data_q + 32'd1;
                        end
                        if (block_done) begin
                            state_q <= ST_CLOSE;
                        end
                    end
                end
                ST_CLOSE: begin
                    if (!sd_start_q && SDctrl_available) begin
                        block_q <= block_q + BLOCK_IDX_W'(1);
                        state_q <= (stop_req_q && fifo_empty) ? ST_IDLE : ST_ARM;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SDctrl_start   = sd_start_q;
    assign SDctrl_address = sd_block_addr(block_q);
    assign busy           = (state_q != ST_IDLE);
    assign nb_data        = nb_data_q;
    assign state          = state_q;

endmodule

// File: tb/tb_sd_recorder.sv
// Bench for sd_recorder: FIFO and SD controller models drive the DUT, a block-level model predicts bytes.
// Latency: not applicable.
// Backpressure: controller model spaces wreq pulses 3 to 5 cycles apart.
module tb_sd_recorder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [22:0] start_block = '0;
    logic        fifo_empty;
    logic        fifo_prog;
    logic        fifo_rd;
    logic [15:0] fifo_data = '0;
    logic        SDctrl_available = 1'b1;
    logic        SDctrl_wreq = 1'b0;
    logic        SDctrl_start;
    logic [31:0] SDctrl_address;
    logic [7:0]  SDctrl_wdata;
    logic        busy;
    logic [31:0] nb_data;
    logic [2:0]  state;

    int total = 0;
    int bad = 0;

    logic [15:0] fq[$];        // FIFO contents
    logic [15:0] mq[$];        // reference: samples not yet placed in a block
    int          fifo_cnt = 0;
    int          prog_thresh = 256;
    int          exp_nb = 0;

    always #5 clk = ~clk;

    sd_recorder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stop             (stop),
        .start_block      (start_block),
        .fifo_empty       (fifo_empty),
        .fifo_prog        (fifo_prog),
        .fifo_rd          (fifo_rd),
        .fifo_data        (fifo_data),
        .SDctrl_available (SDctrl_available),
        .SDctrl_wreq      (SDctrl_wreq),
        .SDctrl_start     (SDctrl_start),
        .SDctrl_address   (SDctrl_address),
        .SDctrl_wdata     (SDctrl_wdata),
        .busy             (busy),
        .nb_data          (nb_data),
        .state            (state)
    );

    // FIFO model: read data appears the cycle after the strobe; flags are registered.
    assign fifo_empty = (fifo_cnt == 0);
    assign fifo_prog  = (fifo_cnt >= prog_thresh);
    always @(posedge clk) begin
        if (fifo_rd && fq.size() > 0) fifo_data <= fq.pop_front();
        fifo_cnt <= fq.size();
    end

    task automatic load_words(input int n, input bit ramp);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = ramp ? 16'(i) : 16'($urandom);
            fq.push_back(w);
            mq.push_back(w);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [22:0] blk);
        @(negedge clk);
        start_block = blk;
        start = 1'b1;
        exp_nb = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Acts as the SD controller for one block and checks command, bytes and sample count.
    task automatic run_block(input logic [31:0] exp_addr, input int hold_cycles);
        logic [7:0]  got[$];
        logic [7:0]  exp[$];
        logic [15:0] w;
        int n;
        int nbad;
        int first;
        n = 0;
        while (SDctrl_start !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (SDctrl_start !== 1'b1) begin
            bad++;
            $display("FAIL cmd_timeout: SDctrl_start=%b required 1", SDctrl_start);
            return;
        end
        total++;
        if (SDctrl_address !== exp_addr) begin
            bad++;
            $display("FAIL cmd_addr: got %h want %h", SDctrl_address, exp_addr);
        end
        if (hold_cycles > 0) begin
            n = 0;
            repeat (hold_cycles) begin
                @(negedge clk);
                if (SDctrl_start !== 1'b1) n++;
            end
            total++;
            if (n != 0) begin
                bad++;
                $display("FAIL start_hold: dropped in %0d of %0d cycles, required 0", n, hold_cycles);
            end
        end
        SDctrl_available = 1'b0;
        @(negedge clk);
        total++;
        if (SDctrl_start !== 1'b0) begin
            bad++;
            $display("FAIL start_drop: SDctrl_start=%b required 0", SDctrl_start);
        end
        for (int i = 0; i < 512; i++) begin
            SDctrl_wreq = 1'b1;
            got.push_back(SDctrl_wdata);
            @(negedge clk);
            SDctrl_wreq = 1'b0;
            repeat (2 + $urandom_range(0, 2)) @(negedge clk);
        end
        // Reference: the next 256 unplaced samples, zero words once they run out.
        for (int i = 0; i < 256; i++) begin
            if (mq.size() > 0) begin
                w = mq.pop_front();
                exp_nb++;
            end else begin
                w = 16'h0000;
            end
            exp.push_back(w[7:0]);
            exp.push_back(w[15:8]);
        end
        nbad = 0;
        first = -1;
        for (int i = 0; i < 512; i++) begin
            if (got[i] !== exp[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL block_bytes @%h: %0d wrong, first at %0d got %h want %h",
                     exp_addr, nbad, first, got[first], exp[first]);
        end
        SDctrl_available = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (nb_data !== 32'(exp_nb)) begin
            bad++;
            $display("FAIL nb_data_block: got %0d want %0d", nb_data, exp_nb);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({state, busy, fifo_rd, SDctrl_start} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: state=%b busy=%b rd=%b start=%b required all 0", state, busy, fifo_rd, SDctrl_start);
        end
        total++;
        if ({SDctrl_wdata, nb_data, SDctrl_address} !== 72'b0) begin
            bad++;
            $display("FAIL reset_data: wdata=%h nb=%h addr=%h required 0", SDctrl_wdata, nb_data, SDctrl_address);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load_words(512, 1'b1);
        @(negedge clk);
        start_block = 23'd5;
        start = 1'b1;
        exp_nb = 0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (SDctrl_start !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: SDctrl_start=%b required 0 two cycles after start", SDctrl_start);
        end
        @(posedge clk);
        #1;
        total++;
        if (SDctrl_start !== 1'b1) begin
            bad++;
            $display("FAIL latency: SDctrl_start=%b required 1 three cycles after start", SDctrl_start);
        end
        run_block(32'h0000_0A00, 20);
        run_block(32'h0000_0C00, 0);
        total++;
        if (state !== 3'b001 || SDctrl_start !== 1'b0) begin
            bad++;
            $display("FAIL basic_wait: state=%b start=%b required 001/0", state, SDctrl_start);
        end
        pulse_stop();
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || nb_data !== 32'd512) begin
            bad++;
            $display("FAIL basic_end: busy=%b nb=%0d required 0/512", busy, nb_data);
        end
    endtask

    task automatic test_stop_flush();
        logic [22:0] blk;
        logic [22:0] blk2;
        blk  = 23'($urandom);
        blk2 = blk + 23'd1;
        load_words(300, 1'b0);
        pulse_start(blk);
        run_block({blk, 9'b0}, 0);
        pulse_stop();
        run_block({blk2, 9'b0}, 0);
        total++;
        if (busy !== 1'b0 || nb_data !== 32'd300) begin
            bad++;
            $display("FAIL flush_end: busy=%b nb=%0d required 0/300", busy, nb_data);
        end
    endtask

    task automatic test_no_prog();
        int hi;
        load_words(10, 1'b0);
        pulse_start(23'h123);
        hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (SDctrl_start !== 1'b0) hi++;
        end
        total++;
        if (hi != 0 || state !== 3'b001) begin
            bad++;
            $display("FAIL no_prog: start high %0d cycles state=%b required 0/001", hi, state);
        end
        pulse_stop();
        run_block({23'h123, 9'b0}, 0);
        total++;
        if (busy !== 1'b0 || nb_data !== 32'd10) begin
            bad++;
            $display("FAIL no_prog_end: busy=%b nb=%0d required 0/10", busy, nb_data);
        end
    endtask

    task automatic test_underrun();
        logic [22:0] blk;
        blk = 23'($urandom);
        prog_thresh = 100;
        load_words(100, 1'b0);
        pulse_start(blk);
        run_block({blk, 9'b0}, 0);
        repeat (5) @(negedge clk);
        total++;
        if (state !== 3'b001 || SDctrl_start !== 1'b0) begin
            bad++;
            $display("FAIL underrun_wait: state=%b start=%b required 001/0", state, SDctrl_start);
        end
        pulse_stop();
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || nb_data !== 32'd100) begin
            bad++;
            $display("FAIL underrun_end: busy=%b nb=%0d required 0/100", busy, nb_data);
        end
        prog_thresh = 256;
    endtask

    task automatic test_reset_mid_write();
        int n;
        load_words(256, 1'b0);
        pulse_start(23'h55);
        n = 0;
        while (SDctrl_start !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        SDctrl_available = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            SDctrl_wreq = 1'b1;
            @(negedge clk);
            SDctrl_wreq = 1'b0;
            repeat (3) @(negedge clk);
        end
        total++;
        if (state !== 3'b011) begin
            bad++;
            $display("FAIL pre_reset_state: state=%b required 011", state);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({state, busy, fifo_rd, SDctrl_start} !== 6'b0) begin
            bad++;
            $display("FAIL midreset_ctrl: state=%b busy=%b rd=%b start=%b required all 0", state, busy, fifo_rd, SDctrl_start);
        end
        total++;
        if ({SDctrl_wdata, nb_data, SDctrl_address} !== 72'b0) begin
            bad++;
            $display("FAIL midreset_data: wdata=%h nb=%h addr=%h required 0", SDctrl_wdata, nb_data, SDctrl_address);
        end
        SDctrl_available = 1'b1;
        fq.delete();
        mq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_words(512, 1'b0);
        pulse_start(23'h7FFFFF);
        run_block(32'hFFFF_FE00, 0);
        run_block(32'h0000_0000, 0);
        pulse_stop();
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || nb_data !== 32'd512) begin
            bad++;
            $display("FAIL wrap_end: busy=%b nb=%0d required 0/512", busy, nb_data);
        end
    endtask

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stop_flush();
        test_no_prog();
        test_underrun();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
